// File: rtl/sc_score_pkg.sv
// Shared constants and state encoding for the score binary-to-BCD converter.
package sc_score_pkg;

    localparam int SC_N_DEF      = 8;
    localparam int SC_DIGITS_DEF = 3;
    localparam int SC_NIB_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } sc_state_e;

endpackage

// File: rtl/sc_score_bcd_if.sv
// Score bus into the converter and decimal display bus out of it.
interface sc_score_bcd_if
    import sc_score_pkg::*;
#(
    parameter int N      = SC_N_DEF,
    parameter int DIGITS = SC_DIGITS_DEF
);
    logic [N-1:0]          SC_SCORE_BCD_BIN;
    logic [4*DIGITS-1:0]   SC_SCORE_BCD_DIGITS;
    logic [DIGITS-1:0]     SC_SCORE_BCD_BLANK;
    logic                  SC_SCORE_BCD_UPDATED;
    logic                  SC_SCORE_BCD_BUSY;

    modport master (
        output SC_SCORE_BCD_BIN,
        input  SC_SCORE_BCD_DIGITS,
        input  SC_SCORE_BCD_BLANK,
        input  SC_SCORE_BCD_UPDATED,
        input  SC_SCORE_BCD_BUSY
    );

    modport slave (
        input  SC_SCORE_BCD_BIN,
        output SC_SCORE_BCD_DIGITS,
        output SC_SCORE_BCD_BLANK,
        output SC_SCORE_BCD_UPDATED,
        output SC_SCORE_BCD_BUSY
    );
endinterface

// File: rtl/sc_score_bcd_add3.sv
// Double-dabble correction cell: a nibble of 5 or more gets 3 added before the shift.
module sc_bcd_add3
    import sc_score_pkg::*;
(
    input  logic [SC_NIB_W-1:0] nib_i,
    output logic [SC_NIB_W-1:0] nib_o
);
    always_comb begin
        nib_o = nib_i;
        if (nib_i >= 4'd5) begin
            nib_o = nib_i + 4'd3;
        end
    end
endmodule

// File: rtl/sc_score_bcd.sv
// Sequential double-dabble converter: re-converts whenever the score bus differs
// from the last captured value, one bit per clock, with registered digits and blank mask.
//   state    | meaning
//   ST_IDLE  | waiting for the score to differ from last_q
//   ST_SHIFT | add-3 then shift {bcd, bin} left, N cycles
//   ST_DONE  | load digits/blank, pulse updated, back to idle
module sc_score_bcd
    import sc_score_pkg::*;
#(
    parameter int N      = SC_N_DEF,
    parameter int DIGITS = SC_DIGITS_DEF
)(
    input  logic             SC_SCORE_BCD_CLOCK,
    input  logic             SC_SCORE_BCD_RESET_InLow,
    sc_score_bcd_if.slave    bus
);
    localparam int CNT_W = $clog2(N + 1);
    localparam int BCD_W = 4 * DIGITS;

    sc_state_e           state_q, state_d;
    logic [N-1:0]        last_q, last_d;
    logic [N-1:0]        bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BCD_W-1:0]    digits_q, digits_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic                updated_q, updated_d;
    logic [BCD_W-1:0]    bcd_adj;
    logic [DIGITS-1:0]   blank_nx;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        sc_bcd_add3 u_add3 (
            .nib_i (bcd_q[4*g +: 4]),
            .nib_o (bcd_adj[4*g +: 4])
        );
    end

    // A digit is blanked only if it and every more significant digit is zero.
    always_comb begin
        blank_nx = '0;
        blank_nx[DIGITS-1] = (bcd_q[4*(DIGITS-1) +: 4] == 4'd0);
        for (int i = DIGITS - 2; i >= 1; i--) begin
            blank_nx[i] = blank_nx[i+1] & (bcd_q[4*i +: 4] == 4'd0);
        end
        blank_nx[0] = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        digits_d  = digits_q;
        blank_d   = blank_q;
        updated_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.SC_SCORE_BCD_BIN != last_q) begin
                    last_d  = bus.SC_SCORE_BCD_BIN;
                    bin_d   = bus.SC_SCORE_BCD_BIN;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(N);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                digits_d  = bcd_q;
                blank_d   = blank_nx;
                updated_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge SC_SCORE_BCD_CLOCK or negedge SC_SCORE_BCD_RESET_InLow) begin
        if (!SC_SCORE_BCD_RESET_InLow) begin
            state_q   <= ST_IDLE;
            last_q    <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            digits_q  <= '0;
            blank_q   <= {{(DIGITS-1){1'b1}}, 1'b0};
            updated_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            blank_q   <= blank_d;
            updated_q <= updated_d;
        end
    end

    assign bus.SC_SCORE_BCD_DIGITS  = digits_q;
    assign bus.SC_SCORE_BCD_BLANK   = blank_q;
    assign bus.SC_SCORE_BCD_UPDATED = updated_q;
    assign bus.SC_SCORE_BCD_BUSY    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_sc_score_bcd.sv
// Directed bench for sc_score_bcd: reset values, latency, back-to-back, mid-conversion reset, full sweep.
module tb_sc_score_bcd;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    sc_score_bcd_if #(.N(8), .DIGITS(3)) bus ();

    sc_score_bcd #(.N(8), .DIGITS(3)) u_dut (
        .SC_SCORE_BCD_CLOCK       (clk),
        .SC_SCORE_BCD_RESET_InLow (rst_n),
        .bus                      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Counts negedges until UPDATED; lat is edges from the capture edge (-1 on timeout).
    task automatic wait_upd(output int lat, output int busy_cnt);
        lat = -1;
        busy_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.SC_SCORE_BCD_BUSY) busy_cnt++;
            if (bus.SC_SCORE_BCD_UPDATED) begin
                lat = c - 1;
                break;
            end
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [2:0] ref_blank(input int v);
        ref_blank = {(v < 100), (v < 10), 1'b0};
    endfunction

    task automatic convert(input int v, input logic [11:0] exp_d, input logic [2:0] exp_b);
        int lat, bc;
        string t;
        t = $sformatf("v%0d", v);
        bus.SC_SCORE_BCD_BIN = 8'(v);
        wait_upd(lat, bc);
        chk({t, "_lat"}, lat, 9);
        chk({t, "_busy"}, bc, 9);
        chk({t, "_digits"}, bus.SC_SCORE_BCD_DIGITS, exp_d);
        chk({t, "_blank"}, bus.SC_SCORE_BCD_BLANK, exp_b);
        @(negedge clk);
        chk({t, "_upd_1cyc"}, bus.SC_SCORE_BCD_UPDATED, 1'b0);
    endtask

    initial begin
        int lat, bc, upd_seen, busy_seen, gap, busy_run, busy_max;
        n_cmp = 0;
        n_mis = 0;
        rst_n = 1'b0;
        bus.SC_SCORE_BCD_BIN = '0;
        repeat (3) @(negedge clk);
        chk("rst_digits", bus.SC_SCORE_BCD_DIGITS, 12'h000);
        chk("rst_blank", bus.SC_SCORE_BCD_BLANK, 3'b110);
        chk("rst_upd", bus.SC_SCORE_BCD_UPDATED, 1'b0);
        chk("rst_busy", bus.SC_SCORE_BCD_BUSY, 1'b0);
        rst_n = 1'b1;

        upd_seen = 0;
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.SC_SCORE_BCD_UPDATED) upd_seen++;
            if (bus.SC_SCORE_BCD_BUSY) busy_seen++;
        end
        chk("idle0_upd", upd_seen, 0);
        chk("idle0_busy", busy_seen, 0);
        chk("idle0_digits", bus.SC_SCORE_BCD_DIGITS, 12'h000);
        chk("idle0_blank", bus.SC_SCORE_BCD_BLANK, 3'b110);

        convert(57, 12'h057, 3'b100);
        convert(255, 12'h255, 3'b000);
        convert(100, 12'h100, 3'b000);
        convert(7, 12'h007, 3'b110);

        // Same value again: no conversion, no pulse.
        upd_seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.SC_SCORE_BCD_UPDATED) upd_seen++;
        end
        chk("same_no_upd", upd_seen, 0);

        // Change mid-conversion: first result stands, second conversion follows.
        bus.SC_SCORE_BCD_BIN = 8'd10;
        repeat (3) @(negedge clk);
        bus.SC_SCORE_BCD_BIN = 8'd92;
        wait_upd(lat, bc);
        chk("b2b_lat1", lat + 3, 9);
        chk("b2b_digits1", bus.SC_SCORE_BCD_DIGITS, 12'h010);
        chk("b2b_blank1", bus.SC_SCORE_BCD_BLANK, 3'b100);
        wait_upd(gap, bc);
        chk("b2b_gap", gap + 1, 10);
        chk("b2b_digits2", bus.SC_SCORE_BCD_DIGITS, 12'h092);
        chk("b2b_blank2", bus.SC_SCORE_BCD_BLANK, 3'b100);

        // Reset during SHIFT.
        @(negedge clk);
        bus.SC_SCORE_BCD_BIN = 8'd200;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", bus.SC_SCORE_BCD_BUSY, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_digits", bus.SC_SCORE_BCD_DIGITS, 12'h000);
        chk("mid_rst_blank", bus.SC_SCORE_BCD_BLANK, 3'b110);
        chk("mid_rst_busy", bus.SC_SCORE_BCD_BUSY, 1'b0);
        upd_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.SC_SCORE_BCD_UPDATED) upd_seen++;
        end
        chk("mid_rst_upd", upd_seen, 0);
        rst_n = 1'b1;
        wait_upd(lat, bc);
        chk("post_rst_lat", lat, 9);
        chk("post_rst_digits", bus.SC_SCORE_BCD_DIGITS, 12'h200);
        chk("post_rst_blank", bus.SC_SCORE_BCD_BLANK, 3'b000);

        // Full sweep against a plain decimal reference.
        busy_max = 0;
        for (int v = 0; v < 256; v++) begin
            bus.SC_SCORE_BCD_BIN = 8'(v);
            busy_run = 0;
            lat = -1;
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                if (bus.SC_SCORE_BCD_BUSY) begin
                    busy_run++;
                    if (busy_run > busy_max) busy_max = busy_run;
                end else begin
                    busy_run = 0;
                end
                if (bus.SC_SCORE_BCD_UPDATED) begin
                    lat = c - 1;
                    break;
                end
            end
            if (lat < 0) chk($sformatf("sweep_timeout_%0d", v), 32'(lat), 32'd9);
            chk($sformatf("sweep_digits_%0d", v), bus.SC_SCORE_BCD_DIGITS, ref_bcd(v));
            chk($sformatf("sweep_blank_%0d", v), bus.SC_SCORE_BCD_BLANK, ref_blank(v));
        end
        chk("sweep_busy_max", busy_max, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/sc_score_bcd.md
# sc_score_bcd

Sequential binary-to-BCD converter sitting directly downstream of the score counter. It consumes the counter's 8-bit score bus and produces three registered decimal digits, plus a leading-zero blank mask, for the seven-segment score display driver. It uses a shift-and-add-3 (double-dabble) datapath, one bit per clock. It re-converts automatically whenever the score bus changes.

## Interface
- N, 8: width of binary input; legal range 4..8.
- DIGITS, 3: number of BCD output digits; must satisfy 10^DIGITS > 2^N - 1.
- SC_SCORE_BCD_CLOCK  input  1  single system clock, rising edge.
- SC_SCORE_BCD_RESET_InLow  input  1  asynchronous, active-low reset.
- SC_SCORE_BCD_BIN  input  N  binary score from the counter; treated as synchronous to the clock.
- SC_SCORE_BCD_DIGITS  output  4*DIGITS  registered BCD digits; hundreds in [11:8], tens in [7:4], units in [3:0].
- SC_SCORE_BCD_BLANK  output  DIGITS  registered leading-zero mask; bit i high means digit i is a suppressed leading zero. Bit 0 is always low.
- SC_SCORE_BCD_UPDATED  output  1  one-cycle active-high pulse when DIGITS/BLANK take a new value.
- SC_SCORE_BCD_BUSY  output  1  high while a conversion is in progress (SHIFT or DONE).

## Operation
- Internal registers:
  - R_Last (N bits): last captured input.
  - R_Bin (N bits): shift register.
  - R_Bcd (4*DIGITS bits): BCD accumulator.
  - R_Cnt (ceil(log2(N+1)) bits): shift counter.
  - State register.
- **IDLE**:
  - If BIN != R_Last: R_Last <= BIN, R_Bin <= BIN, R_Bcd <= 0, R_Cnt <= N, go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT**, each cycle:
  - Every BCD nibble ≥ 5 gets +3 (combinational, all nibbles in parallel).
  - Then {R_Bcd, R_Bin} shifts left by 1.
  - R_Cnt decrements.
  - When R_Cnt reaches 1 (the last shift), go to DONE.
- **DONE**, one cycle:
  - DIGITS <= R_Bcd.
  - BLANK bit i (i ≥ 1) <= 1 iff digit i and all higher digits are zero.
  - UPDATED asserted. Go to IDLE.
- BIN changes during SHIFT/DONE are ignored. On return to IDLE, BIN is compared against R_Last again, so the outputs always converge to the latest stable input.
- Add-3 results fit in 4 bits; no carry leaves a nibble. Overflow beyond DIGITS is impossible under the parameter rule.
- Outputs hold their values between conversions. There is no other path that writes DIGITS or BLANK.

## Timing
- Reset values:
  - DIGITS = 0, BLANK = {1..1,0} (all but bit 0 high), UPDATED = 0, BUSY = 0.
  - R_Last = 0, state = IDLE.
  - An input of 0 after reset therefore triggers no conversion.
- Latency:
  - BIN change is captured at clock edge k.
  - Shifts occur on edges k+1 .. k+N.
  - DIGITS/BLANK update and UPDATED goes high after edge k+N+1, for exactly one cycle.
  - Total N+1 clocks from capture; 9 clocks at default N.
- BUSY is high from after edge k until after edge k+N+1.
- Back-to-back conversions: at the earliest, a new capture occurs on the edge after DONE. UPDATED pulses are therefore at least N+2 cycles apart.
- Reset asserted mid-conversion:
  - Immediate, asynchronous return to IDLE with reset values; the partial result is discarded.
  - After release, a nonzero BIN starts a fresh conversion on the first clock edge.
- BIN equal to R_Last on return to IDLE: no conversion, no UPDATED pulse.

## Structure
- Shared package sc_score_pkg:
  - state encoding constants: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10;
  - default N and DIGITS constants;
  - BCD nibble width constant (4).
- Sub-module sc_bcd_add3: combinational 4-bit "if ≥5 add 3" cell, instantiated once per digit via generate.
- Top level holds the FSM, shift register, counter, change detector and output registers.

## Test plan
- Reset, then hold BIN=0 for 20 cycles -> DIGITS=0x000, BLANK=3'b110, UPDATED never pulses, BUSY stays 0.
- BIN 0 -> 57 -> BUSY high for 9 cycles; UPDATED pulses once, 9 cycles after capture; DIGITS=0x057, BLANK=3'b100.
- BIN=255 -> DIGITS=0x255, BLANK=3'b000. BIN=100 -> DIGITS=0x100, BLANK=3'b000. BIN=7 -> DIGITS=0x007, BLANK=3'b110.
- BIN=10, then change to 92 three cycles after capture -> first UPDATED gives 0x010; a second conversion starts on the edge after DONE; second UPDATED gives 0x092, 10 cycles after the first.
- Assert reset during SHIFT with BIN=200 -> outputs return to reset values immediately, no UPDATED; after release, conversion restarts and yields 0x200 after 9 cycles.
- Sweep BIN 0..255, waiting for each UPDATED -> DIGITS matches the reference decimal of BIN for every value; BUSY never exceeds 9 consecutive cycles.
